fetch_mem_unit: RTL and testbench

- Datapath front end of the multicycle MIPS core; sits directly under ControlUnit.
- Holds PC, Instruction Register (IR) and Memory Data Register (MDR), and drives the single shared instruction/data memory port.
- Executes ControlUnit strobes IorD, IRWrite, MemWrite, PcWrite, Branch and PcSrc, plus one added strobe, data_read.
- Returns opcode/funct to ControlUnit and stalls it while memory is busy.

---
 rtl/mips_pkg.sv | 30 +++
 rtl/mem_port_fsm.sv | 94 +++++++++
 rtl/fetch_mem_unit.sv | 103 ++++++++++
 tb/tb_fetch_mem_unit.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Types and constants shared by the multicycle MIPS datapath front end and ControlUnit.
package mips_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mem_state_e;

  typedef enum logic [1:0] {
    TGT_NONE = 2'd0,
    TGT_IR   = 2'd1,
    TGT_MDR  = 2'd2
  } read_tgt_e;

  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;
  localparam int FUNCT_MSB  = 5;
  localparam int FUNCT_LSB  = 0;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // A store wins over a fetch, which wins over a load; a store has no read target.
  function automatic read_tgt_e select_target(input logic wr, input logic irw, input logic rd);
    if (wr)  return TGT_NONE;
    if (irw) return TGT_IR;
    if (rd)  return TGT_MDR;
    return TGT_NONE;
  endfunction

endpackage

// File: rtl/mem_port_fsm.sv
// Shared memory port sequencer: IDLE/BUSY handshake, request capture, timeout and stall.
module mem_port_fsm
  import mips_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        access_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  read_tgt_e   tgt_i,
  input  logic        mem_ready_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic        stall_o,
  output logic        done_o,
  output read_tgt_e   done_tgt_o,
  output logic        bus_error_o
);

  localparam int            CW       = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX  = '1;

  mem_state_e    state_q;
  logic [CW-1:0] cnt_q;
  logic          bus_error_q;
  logic          we_q;
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;
  read_tgt_e     tgt_q;

  logic busy;
  logic timeout_hit;

  always_comb begin
    busy        = (state_q == BUSY);
    timeout_hit = busy && (cnt_q == CNT_LAST);
    // Reset is folded in so the memory sees the request drop the instant reset rises.
    mem_req_o   = !rst_i && (busy || access_i);
    mem_we_o    = busy ? we_q    : we_i;
    mem_addr_o  = busy ? addr_q  : addr_i;
    mem_wdata_o = busy ? wdata_q : wdata_i;
    stall_o     = !rst_i && ((!busy && access_i && !mem_ready_i) ||
                             (busy && !mem_ready_i && !timeout_hit));
    done_o      = !rst_i && mem_ready_i && (busy || access_i);
    done_tgt_o  = busy ? tgt_q : tgt_i;
    bus_error_o = bus_error_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bus_error_q <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      tgt_q       <= TGT_NONE;
    end else begin
      case (state_q)
        IDLE: begin
          if (access_i && !mem_ready_i) begin
            state_q <= BUSY;
            cnt_q   <= '0;
            we_q    <= we_i;
            addr_q  <= addr_i;
            wdata_q <= wdata_i;
            tgt_q   <= tgt_i;
          end
        end
        BUSY: begin
          if (mem_ready_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else if (timeout_hit) begin
            // Abandon the access: no register is written and ControlUnit is released.
            state_q     <= IDLE;
            cnt_q       <= '0;
            bus_error_q <= 1'b1;
          end else if (cnt_q != CNT_MAX) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/fetch_mem_unit.sv
// Multicycle MIPS front end: PC, IR and MDR around one shared instruction/data memory port.
module fetch_mem_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          TIMEOUT  = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        iord,
  input  logic        ir_write,
  input  logic        data_read,
  input  logic        mem_write,
  input  logic        pc_write,
  input  logic        branch,
  input  logic        zero,
  input  logic        pc_src,
  input  logic [31:0] alu_result,
  input  logic [31:0] alu_out,
  input  logic [31:0] store_data,
  output logic [31:0] pc,
  output logic [31:0] instr,
  output logic [31:0] mdr,
  output logic [5:0]  opcode,
  output logic [5:0]  funct,
  output logic        stall,
  output logic        bus_error,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] mdr_q, mdr_d;

  logic        access;
  read_tgt_e   req_tgt;
  logic [31:0] req_addr;
  logic        done;
  read_tgt_e   done_tgt;
  logic        pc_en;

  always_comb begin
    access   = mem_write || ir_write || data_read;
    req_tgt  = select_target(mem_write, ir_write, data_read);
    req_addr = iord ? alu_out : pc_q;
  end

  mem_port_fsm #(
    .TIMEOUT(TIMEOUT)
  ) u_mem_port_fsm (
    .clk_i       (clock),
    .rst_i       (reset),
    .access_i    (access),
    .we_i        (mem_write),
    .addr_i      (req_addr),
    .wdata_i     (store_data),
    .tgt_i       (req_tgt),
    .mem_ready_i (mem_ready),
    .mem_req_o   (mem_req),
    .mem_we_o    (mem_we),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .stall_o     (stall),
    .done_o      (done),
    .done_tgt_o  (done_tgt),
    .bus_error_o (bus_error)
  );

  // The PC may advance on a fetch's completing edge; the IR still gets the old-PC word.
  always_comb begin
    pc_en = (pc_write || (branch && zero)) && !stall;
    pc_d  = pc_q;
    if (pc_en) pc_d = pc_src ? alu_out : alu_result;
    ir_d  = (done && (done_tgt == TGT_IR))  ? mem_rdata : ir_q;
    mdr_d = (done && (done_tgt == TGT_MDR)) ? mem_rdata : mdr_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_q  <= RESET_PC;
      ir_q  <= '0;
      mdr_q <= '0;
    end else begin
      pc_q  <= pc_d;
      ir_q  <= ir_d;
      mdr_q <= mdr_d;
    end
  end

  always_comb begin
    pc     = pc_q;
    instr  = ir_q;
    mdr    = mdr_q;
    opcode = ir_q[OPCODE_MSB:OPCODE_LSB];
    funct  = ir_q[FUNCT_MSB:FUNCT_LSB];
  end

endmodule

// File: tb/tb_fetch_mem_unit.sv
// Scenario bench for fetch_mem_unit: memory handshakes driven directly, completions scored via a queue.
module tb_fetch_mem_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        iord, ir_write, data_read, mem_write, pc_write, branch, zero, pc_src;
  logic [31:0] alu_result, alu_out, store_data;
  logic [31:0] pc, instr, mdr;
  logic [5:0]  opcode, funct;
  logic        stall, bus_error, mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ready;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] ir;
    logic [31:0] mdr;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        ex;
  int          total = 0;
  int          bad   = 0;
  logic [31:0] m_pc, m_ir, m_mdr;

  fetch_mem_unit #(
    .RESET_PC (32'h0000_0000),
    .TIMEOUT  (4)
  ) dut (
    .clock(clock), .reset(reset), .iord(iord), .ir_write(ir_write), .data_read(data_read),
    .mem_write(mem_write), .pc_write(pc_write), .branch(branch), .zero(zero), .pc_src(pc_src),
    .alu_result(alu_result), .alu_out(alu_out), .store_data(store_data),
    .pc(pc), .instr(instr), .mdr(mdr), .opcode(opcode), .funct(funct), .stall(stall),
    .bus_error(bus_error), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic quiet();
    iord = 0; ir_write = 0; data_read = 0; mem_write = 0; pc_write = 0;
    branch = 0; zero = 0; pc_src = 0; mem_ready = 0; mem_rdata = 32'h0;
  endtask

  task automatic test_reset();
    #2;
    total++; if (pc !== 32'h0) begin bad++; $display("FAIL rst_pc got=%h want=%h", pc, 32'h0); end
    total++; if (instr !== 32'h0) begin bad++; $display("FAIL rst_instr got=%h want=0", instr); end
    total++; if (mdr !== 32'h0) begin bad++; $display("FAIL rst_mdr got=%h want=0", mdr); end
    total++; if ({mem_req, stall, bus_error} !== 3'b000)
      begin bad++; $display("FAIL rst_flags got=%b want=000", {mem_req, stall, bus_error}); end
    @(negedge clock); reset = 0;
    m_pc = 32'h0; m_ir = 32'h0; m_mdr = 32'h0;
    $display("reset released: pc=%h", pc);
  endtask

  task automatic test_zero_wait_fetch();
    @(negedge clock);
    ir_write = 1; pc_write = 1; pc_src = 0; alu_result = 32'h4; iord = 0;
    mem_ready = 1; mem_rdata = 32'h2108_0005;
    m_ir = 32'h2108_0005;
    sb_q.push_back('{addr: m_pc, we: 1'b0, wdata: 32'h0, ir: m_ir, mdr: m_mdr});
    #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL zw_stall got=%b want=0", stall); end
    total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL zw_req got=%b want=1", mem_req); end
    ex = sb_q.pop_front();
    total++; if ({mem_we, mem_addr} !== {ex.we, ex.addr})
      begin bad++; $display("FAIL zw_addr got=%b/%h want=%b/%h", mem_we, mem_addr, ex.we, ex.addr); end
    m_pc = 32'h4;
    @(negedge clock); quiet(); #1;
    total++; if (instr !== ex.ir) begin bad++; $display("FAIL zw_instr got=%h want=%h", instr, ex.ir); end
    total++; if ({opcode, funct} !== {6'h08, 6'h05})
      begin bad++; $display("FAIL zw_fields got=%h/%h want=08/05", opcode, funct); end
    total++; if (pc !== m_pc) begin bad++; $display("FAIL zw_pc got=%h want=%h", pc, m_pc); end
    $display("fetch zero-wait: instr=%h pc=%h", instr, pc);
  endtask

  task automatic test_wait_load();
    int stall_cnt = 0;
    @(negedge clock);
    iord = 1; alu_out = 32'h100; data_read = 1;
    m_mdr = 32'hDEAD_BEEF;
    sb_q.push_back('{addr: 32'h100, we: 1'b0, wdata: 32'h0, ir: m_ir, mdr: m_mdr});
    for (int c = 0; c < 4; c++) begin
      if (c > 0) begin @(negedge clock); alu_out = 32'h200 + c; end
      mem_ready = (c == 3);
      mem_rdata = (c == 3) ? 32'hDEAD_BEEF : 32'h0BAD_0BAD;
      #1;
      if (stall) stall_cnt++;
      total++; if (mem_addr !== 32'h100)
        begin bad++; $display("FAIL ld_addr cyc=%0d got=%h want=%h", c, mem_addr, 32'h100); end
      if (c == 3) begin
        ex = sb_q.pop_front();
        total++; if ({mem_req, mem_we} !== {1'b1, ex.we})
          begin bad++; $display("FAIL ld_req got=%b%b want=1%b", mem_req, mem_we, ex.we); end
      end
    end
    @(negedge clock); quiet(); #1;
    total++; if (stall_cnt != 3) begin bad++; $display("FAIL ld_stall_cycles got=%0d want=3", stall_cnt); end
    total++; if (mdr !== ex.mdr) begin bad++; $display("FAIL ld_mdr got=%h want=%h", mdr, ex.mdr); end
    total++; if (instr !== ex.ir) begin bad++; $display("FAIL ld_instr got=%h want=%h", instr, ex.ir); end
    total++; if (pc !== m_pc) begin bad++; $display("FAIL ld_pc got=%h want=%h", pc, m_pc); end
    $display("load 3-wait: mdr=%h stall_cycles=%0d", mdr, stall_cnt);
  endtask

  task automatic test_branch();
    @(negedge clock);
    branch = 1; pc_src = 1; alu_out = 32'h40; zero = 1; m_pc = 32'h40;
    @(negedge clock); #1;
    total++; if (pc !== m_pc) begin bad++; $display("FAIL br_taken got=%h want=%h", pc, m_pc); end
    zero = 0; alu_out = 32'h80;
    @(negedge clock); #1;
    total++; if (pc !== m_pc) begin bad++; $display("FAIL br_not_taken got=%h want=%h", pc, m_pc); end
    zero = 1; iord = 0; data_read = 1; mem_ready = 0;
    m_mdr = 32'h1234_5678;
    sb_q.push_back('{addr: m_pc, we: 1'b0, wdata: 32'h0, ir: m_ir, mdr: m_mdr});
    #1;
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL br_stall got=%b want=1", stall); end
    @(negedge clock); #1;
    total++; if (pc !== m_pc) begin bad++; $display("FAIL br_stalled got=%h want=%h", pc, m_pc); end
    branch = 0; mem_ready = 1; mem_rdata = 32'h1234_5678; #1;
    ex = sb_q.pop_front();
    total++; if (mem_addr !== ex.addr) begin bad++; $display("FAIL br_ld_addr got=%h want=%h", mem_addr, ex.addr); end
    @(negedge clock); quiet(); #1;
    total++; if (mdr !== ex.mdr) begin bad++; $display("FAIL br_ld_mdr got=%h want=%h", mdr, ex.mdr); end
    $display("branch: pc=%h mdr=%h", pc, mdr);
  endtask

  task automatic test_priority();
    @(negedge clock);
    mem_write = 1; ir_write = 1; iord = 1; alu_out = 32'h300; store_data = 32'hCAFE_F00D;
    mem_ready = 1; mem_rdata = 32'hFFFF_FFFF;
    sb_q.push_back('{addr: 32'h300, we: 1'b1, wdata: 32'hCAFE_F00D, ir: m_ir, mdr: m_mdr});
    #1;
    ex = sb_q.pop_front();
    total++; if ({mem_we, mem_addr, mem_wdata} !== {ex.we, ex.addr, ex.wdata})
      begin bad++; $display("FAIL pri_req got=%b/%h/%h want=%b/%h/%h", mem_we, mem_addr, mem_wdata, ex.we, ex.addr, ex.wdata); end
    @(negedge clock); quiet(); #1;
    total++; if ({instr, mdr} !== {ex.ir, ex.mdr})
      begin bad++; $display("FAIL pri_regs got=%h/%h want=%h/%h", instr, mdr, ex.ir, ex.mdr); end
    $display("priority store: we=%b instr=%h", ex.we, instr);
  endtask

  task automatic test_back_to_back();
    @(negedge clock);
    ir_write = 1; iord = 0; pc_write = 1; pc_src = 0; alu_result = m_pc + 4; mem_ready = 0;
    sb_q.push_back('{addr: m_pc, we: 1'b0, wdata: 32'h0, ir: 32'hAAAA_0001, mdr: m_mdr});
    sb_q.push_back('{addr: m_pc + 4, we: 1'b0, wdata: 32'h0, ir: 32'hBBBB_0002, mdr: m_mdr});
    @(negedge clock); #1;
    total++; if (pc !== m_pc) begin bad++; $display("FAIL b2b_hold_pc got=%h want=%h", pc, m_pc); end
    mem_ready = 1; mem_rdata = 32'hAAAA_0001; #1;
    ex = sb_q.pop_front();
    total++; if (mem_addr !== ex.addr) begin bad++; $display("FAIL b2b_addr1 got=%h want=%h", mem_addr, ex.addr); end
    m_pc = m_pc + 4;
    @(negedge clock);
    mem_rdata = 32'hBBBB_0002; alu_result = m_pc + 4; #1;
    total++; if (instr !== ex.ir) begin bad++; $display("FAIL b2b_instr1 got=%h want=%h", instr, ex.ir); end
    ex = sb_q.pop_front();
    total++; if ({mem_req, stall, mem_addr} !== {1'b1, 1'b0, ex.addr})
      begin bad++; $display("FAIL b2b_req2 got=%b%b/%h want=10/%h", mem_req, stall, mem_addr, ex.addr); end
    m_pc = m_pc + 4; m_ir = ex.ir;
    @(negedge clock); quiet(); #1;
    total++; if ({instr, pc} !== {m_ir, m_pc})
      begin bad++; $display("FAIL b2b_final got=%h/%h want=%h/%h", instr, pc, m_ir, m_pc); end
    $display("back-to-back: instr=%h pc=%h", instr, pc);
  endtask

  task automatic test_timeout();
    int req_cycles = 0;
    @(negedge clock);
    mem_write = 1; iord = 1; alu_out = 32'h500; store_data = 32'h1; mem_ready = 0; #1;
    total++; if ({mem_req, stall, bus_error} !== 3'b110)
      begin bad++; $display("FAIL to_start got=%b want=110", {mem_req, stall, bus_error}); end
    @(negedge clock); mem_write = 0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (!mem_req) break;
      req_cycles++;
      total++; if ({stall, bus_error} !== {(c < 3), 1'b0})
        begin bad++; $display("FAIL to_busy cyc=%0d got=%b%b want=%b0", c, stall, bus_error, (c < 3)); end
      @(negedge clock);
    end
    total++; if (req_cycles != 4) begin bad++; $display("FAIL to_busy_cycles got=%0d want=4", req_cycles); end
    total++; if ({bus_error, mem_req, stall} !== 3'b100)
      begin bad++; $display("FAIL to_abort got=%b want=100", {bus_error, mem_req, stall}); end
    @(negedge clock);
    data_read = 1; iord = 1; alu_out = 32'h600; mem_ready = 1; mem_rdata = 32'h5555_AAAA;
    m_mdr = 32'h5555_AAAA;
    @(negedge clock); quiet(); #1;
    total++; if ({bus_error, mdr, instr} !== {1'b1, m_mdr, m_ir})
      begin bad++; $display("FAIL to_sticky got=%b/%h/%h want=1/%h/%h", bus_error, mdr, instr, m_mdr, m_ir); end
    $display("timeout: busy_cycles=%0d bus_error=%b", req_cycles, bus_error);
  endtask

  task automatic test_reset_mid_busy();
    @(negedge clock);
    data_read = 1; iord = 0; mem_ready = 0;
    @(negedge clock);
    #2; reset = 1; #1;
    total++; if ({pc, instr, mdr} !== {32'h0, 32'h0, 32'h0})
      begin bad++; $display("FAIL rb_regs got=%h/%h/%h want=0/0/0", pc, instr, mdr); end
    total++; if ({mem_req, stall, bus_error} !== 3'b000)
      begin bad++; $display("FAIL rb_flags got=%b want=000", {mem_req, stall, bus_error}); end
    quiet();
    @(negedge clock); reset = 0; #1;
    total++; if ({mem_req, pc} !== {1'b0, 32'h0})
      begin bad++; $display("FAIL rb_after got=%b/%h want=0/0", mem_req, pc); end
    $display("reset mid-busy: pc=%h mem_req=%b", pc, mem_req);
  endtask

  initial begin
    reset = 1; quiet();
    alu_result = 32'h0; alu_out = 32'h0; store_data = 32'h0;
    test_reset();
    test_zero_wait_fetch();
    test_wait_load();
    test_branch();
    test_priority();
    test_back_to_back();
    test_timeout();
    test_reset_mid_busy();
    total++; if (sb_q.size() != 0) begin bad++; $display("FAIL sb_leftover got=%0d want=0", sb_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
